// File: rtl/btn_updown_counter_if.sv
// ============================================================================
// Module      : btn_updown_counter_if
// Description : Button/load inputs and count/flag outputs of the up/down
//               button counter, bundled as one port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface btn_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       Push;       // active-low buttons: [1] = up, [0] = down
  logic             Load_en;
  logic [WIDTH-1:0] Load_val;
  logic [WIDTH-1:0] Cnt_o_LED;
  logic             Max_o;
  logic             Min_o;
  logic             Evt_o;

  // Stimulus side: drives buttons and load, observes count and flags
  modport master (
    output Push, Load_en, Load_val,
    input  Cnt_o_LED, Max_o, Min_o, Evt_o
  );

  // Counter side
  modport slave (
    input  Push, Load_en, Load_val,
    output Cnt_o_LED, Max_o, Min_o, Evt_o
  );
endinterface

`default_nettype wire

// File: rtl/btn_updown_counter.sv
// ============================================================================
// Module      : btn_updown_counter
// Description : Two-button up/down counter with saturate or wrap bounds,
//               synchronous load and change-event pulse. Buttons are
//               asynchronous and active-low; each one is synchronized and
//               edge-detected so a press counts exactly once.
//               Optional macro BTN_UPDOWN_DEBOUNCE_EN inserts a DB_CYCLES
//               stability filter between synchronizer and edge detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_VAL   = 9,
  parameter int STEP      = 1,
  parameter int WRAP      = 0,
  parameter int DB_CYCLES = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  btn_updown_counter_if.slave  bus
);

  // All count arithmetic is done one bit wider than the counter so the
  // overflow/underflow of a step is visible before it is clamped or wrapped.
  localparam logic [WIDTH:0] L_MAX  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] L_STEP = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] L_MOD  = (WIDTH+1)'(MAX_VAL + 1);

  logic [1:0] valid_q;   // marks when the synchronizer holds real samples
  logic [1:0] press_w;   // one-cycle press strobes: [1] = up, [0] = down

  // Out-of-range filter length: empty marker block, nothing to build
  if (DB_CYCLES < 1) begin : g_cfg_bad_db_cycles
  end

  // After reset the synchronizers hold a forced "released" value; this
  // shift register says when their contents come from the real pins.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= {valid_q[0], 1'b1};
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic meta_q;
    logic sync_q;
    logic lvl_w;
    logic lvl_prev_q;
    logic armed_q;

    // Two-flop synchronizer, idles released (high)
    always_ff @(posedge Clk) begin
      if (Rst) begin
        meta_q <= 1'b1;
        sync_q <= 1'b1;
      end else begin
        meta_q <= bus.Push[b];
        sync_q <= meta_q;
      end
    end

`ifdef BTN_UPDOWN_DEBOUNCE_EN
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] L_LAST = CW'(DB_CYCLES - 1);

    logic          db_q;
    logic [CW-1:0] dbcnt_q;

    // Accept a new level only after DB_CYCLES consecutive differing samples
    always_ff @(posedge Clk) begin
      if (Rst) begin
        db_q    <= 1'b1;
        dbcnt_q <= '0;
      end else if (sync_q != db_q) begin
        if (dbcnt_q == L_LAST) begin
          db_q    <= sync_q;
          dbcnt_q <= '0;
        end else begin
          dbcnt_q <= dbcnt_q + 1'b1;
        end
      end else begin
        dbcnt_q <= '0;
      end
    end

    assign lvl_w = db_q;
`else
    assign lvl_w = sync_q;
`endif

    // Edge history plus arming: a button must be seen released on the real
    // pin after reset before its falling edge may count.
    always_ff @(posedge Clk) begin
      if (Rst) begin
        lvl_prev_q <= 1'b1;
        armed_q    <= 1'b0;
      end else begin
        lvl_prev_q <= lvl_w;
        if (valid_q[1] && sync_q) begin
          armed_q <= 1'b1;
        end
      end
    end

    assign press_w[b] = armed_q & lvl_prev_q & ~lvl_w;
  end

  logic [WIDTH:0] cnt_q;
  logic [WIDTH:0] cnt_d;
  logic           max_q;
  logic           min_q;
  logic           evt_q;
  logic [WIDTH:0] load_w;
  logic [WIDTH:0] up_sum_w;
  logic [WIDTH:0] up_wrap_w;
  logic [WIDTH:0] dn_diff_w;
  logic [WIDTH:0] dn_wrap_w;

  assign load_w    = {1'b0, bus.Load_val};
  assign up_sum_w  = cnt_q + L_STEP;
  assign up_wrap_w = up_sum_w - L_MOD;
  assign dn_diff_w = cnt_q - L_STEP;
  assign dn_wrap_w = cnt_q + L_MOD - L_STEP;

  // Next count: load beats presses; simultaneous up+down cancels out
  always_comb begin
    cnt_d = cnt_q;
    if (bus.Load_en) begin
      cnt_d = (load_w > L_MAX) ? L_MAX : load_w;
    end else if (press_w[1] && !press_w[0]) begin
      if (up_sum_w > L_MAX) begin
        cnt_d = (WRAP != 0) ? up_wrap_w : L_MAX;
      end else begin
        cnt_d = up_sum_w;
      end
    end else if (press_w[0] && !press_w[1]) begin
      if (cnt_q < L_STEP) begin
        cnt_d = (WRAP != 0) ? dn_wrap_w : '0;
      end else begin
        cnt_d = dn_diff_w;
      end
    end
  end

  // Count register with flags derived from the next value so all update together
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= '0;
      max_q <= 1'b0;
      min_q <= 1'b1;
      evt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      max_q <= (cnt_d == L_MAX);
      min_q <= (cnt_d == '0);
      evt_q <= (cnt_d != cnt_q);
    end
  end

  assign bus.Cnt_o_LED = cnt_q[WIDTH-1:0];
  assign bus.Max_o     = max_q;
  assign bus.Min_o     = min_q;
  assign bus.Evt_o     = evt_q;

endmodule

`default_nettype wire

// File: tb/tb_btn_updown_counter.sv
// ============================================================================
// Module      : tb_btn_updown_counter
// Description : Directed bench for btn_updown_counter. Two instances share
//               the stimulus: a default (saturating, STEP 1) counter and a
//               wrapping STEP 3 counter. Expected results are queued when a
//               press is driven and popped when the count should appear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_updown_counter;

  localparam int W  = 4;
  localparam int MX = 9;
`ifdef BTN_UPDOWN_DEBOUNCE_EN
  localparam int LAT = 3 + 4;
`else
  localparam int LAT = 3;
`endif

  typedef struct {
    string tag;
    int    cs;
    int    cw;
    int    es;
    int    ew;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   push = 2'b11;
  logic         load_en = 1'b0;
  logic [W-1:0] load_val = '0;

  exp_t sb[$];
  int   exp_s = 0, exp_w = 0;
  int   ev_s_exp = 0, ev_w_exp = 0;
  int   ev_s = 0, ev_w = 0;
  int   n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  btn_updown_counter_if #(.WIDTH(W)) bus_s ();
  btn_updown_counter_if #(.WIDTH(W)) bus_w ();

  assign bus_s.Push     = push;
  assign bus_s.Load_en  = load_en;
  assign bus_s.Load_val = load_val;
  assign bus_w.Push     = push;
  assign bus_w.Load_en  = load_en;
  assign bus_w.Load_val = load_val;

  btn_updown_counter #(.WIDTH(W), .MAX_VAL(MX), .STEP(1), .WRAP(0), .DB_CYCLES(4)) dut_s (
    .Clk (clk),
    .Rst (rst),
    .bus (bus_s.slave)
  );

  btn_updown_counter #(.WIDTH(W), .MAX_VAL(MX), .STEP(3), .WRAP(1), .DB_CYCLES(4)) dut_w (
    .Clk (clk),
    .Rst (rst),
    .bus (bus_w.slave)
  );

  // Event pulse counters
  always @(negedge clk) begin
    if (bus_s.Evt_o) ev_s++;
    if (bus_w.Evt_o) ev_w++;
  end

  function automatic int nxt(input int c, input bit up, input bit dn, input bit ld,
                             input int lv, input bit wrap, input int step);
    if (ld) return (lv > MX) ? MX : lv;
    if (up && !dn) begin
      if (c + step > MX) return wrap ? (c + step - (MX + 1)) : MX;
      return c + step;
    end
    if (dn && !up) begin
      if (c - step < 0) return wrap ? (c - step + MX + 1) : 0;
      return c - step;
    end
    return c;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input int cs, input int cw);
    check({tag, " s.max"}, int'(bus_s.Max_o), int'(cs == MX));
    check({tag, " s.min"}, int'(bus_s.Min_o), int'(cs == 0));
    check({tag, " w.max"}, int'(bus_w.Max_o), int'(cw == MX));
    check({tag, " w.min"}, int'(bus_w.Min_o), int'(cw == 0));
  endtask

  // Drive one press pattern (or load only when pv = 2'b11) for 'hold' clocks.
  task automatic do_press(input string tag, input logic [1:0] pv, input int hold,
                          input bit ld, input int lv, input bit chk_lat);
    exp_t e;
    int   os;
    bit   up, dn;
    up = !pv[1];
    dn = !pv[0];
    os = exp_s;
    exp_s = nxt(exp_s, up, dn, ld, lv, 1'b0, 1);
    if (exp_s != os) ev_s_exp++;
    begin
      int ow;
      ow = exp_w;
      exp_w = nxt(exp_w, up, dn, ld, lv, 1'b1, 3);
      if (exp_w != ow) ev_w_exp++;
    end
    sb.push_back('{tag, exp_s, exp_w, ev_s_exp, ev_w_exp});
    push = pv;
    for (int k = 1; k <= LAT + hold + 3; k++) begin
      @(negedge clk);
      if (k == hold) push = 2'b11;
      if (k == LAT - 1) begin
        if (ld) begin
          load_en  = 1'b1;
          load_val = W'(lv);
        end
        if (chk_lat) check({tag, " early"}, int'(bus_s.Cnt_o_LED), os);
      end
      if (k == LAT) begin
        load_en = 1'b0;
        e = sb.pop_front();
        check({e.tag, " s.cnt"}, int'(bus_s.Cnt_o_LED), e.cs);
        check({e.tag, " w.cnt"}, int'(bus_w.Cnt_o_LED), e.cw);
        check_flags(e.tag, e.cs, e.cw);
      end
    end
    push = 2'b11;
    check({e.tag, " s.hold"}, int'(bus_s.Cnt_o_LED), e.cs);
    check({e.tag, " w.hold"}, int'(bus_w.Cnt_o_LED), e.cw);
    check({e.tag, " s.evt"}, ev_s, e.es);
    check({e.tag, " w.evt"}, ev_w, e.ew);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst s.cnt", int'(bus_s.Cnt_o_LED), 0);
    check("rst s.evt", int'(bus_s.Evt_o), 0);
    check_flags("rst", 0, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Nine up presses of 200 ns; first one also checks latency
    for (int i = 0; i < 9; i++) do_press("up", 2'b01, 20, 1'b0, 0, i == 0);

    // Up at the bound: saturating stays, wrapping instance wraps
    do_press("up@max", 2'b01, 20, 1'b0, 0, 1'b0);

    // Eight downs, then two more through the lower bound
    for (int i = 0; i < 8; i++) do_press("dn", 2'b10, 20, 1'b0, 0, 1'b0);
    do_press("dn@1", 2'b10, 20, 1'b0, 0, 1'b0);
    do_press("dn@0", 2'b10, 20, 1'b0, 0, 1'b0);

    // Loads, simultaneous press, load overriding a press, equal-value load
    do_press("ld5", 2'b11, 0, 1'b1, 5, 1'b0);
    do_press("both", 2'b00, 20, 1'b0, 0, 1'b0);
    do_press("ld12+up", 2'b01, 20, 1'b1, 12, 1'b0);
    do_press("ld9 eq", 2'b11, 0, 1'b1, 9, 1'b0);
    do_press("ld3", 2'b11, 0, 1'b1, 3, 1'b0);

    // Reset with up held: press to 4, hold through reset, release, press again
    push = 2'b01;
    exp_s = nxt(exp_s, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1);
    exp_w = nxt(exp_w, 1'b1, 1'b0, 1'b0, 0, 1'b1, 3);
    ev_s_exp++;
    ev_w_exp++;
    repeat (LAT + 3) @(negedge clk);
    check("held s.cnt", int'(bus_s.Cnt_o_LED), exp_s);
    check("held w.cnt", int'(bus_w.Cnt_o_LED), exp_w);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    exp_s = 0;
    exp_w = 0;
    check("inrst s.cnt", int'(bus_s.Cnt_o_LED), 0);
    check("inrst w.cnt", int'(bus_w.Cnt_o_LED), 0);
    check_flags("inrst", 0, 0);
    rst = 1'b0;
    repeat (LAT + 10) @(negedge clk);
    check("postrst s.cnt", int'(bus_s.Cnt_o_LED), 0);
    check("postrst w.cnt", int'(bus_w.Cnt_o_LED), 0);
    check("postrst s.evt", ev_s, ev_s_exp);
    push = 2'b11;
    repeat (LAT + 3) @(negedge clk);
    do_press("repress", 2'b01, 20, 1'b0, 0, 1'b1);

`ifdef BTN_UPDOWN_DEBOUNCE_EN
    // Three-clock glitch is filtered; six-clock press counts once
    push = 2'b01;
    repeat (3) @(negedge clk);
    push = 2'b11;
    repeat (LAT + 6) @(negedge clk);
    check("glitch s.cnt", int'(bus_s.Cnt_o_LED), exp_s);
    check("glitch w.cnt", int'(bus_w.Cnt_o_LED), exp_w);
    check("glitch s.evt", ev_s, ev_s_exp);
    do_press("press6", 2'b01, 6, 1'b0, 0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/btn_updown_counter.md
BTN_UPDOWN_COUNTER -- requirements
Module: btn_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits.
REQ-002 Parameter MAX_VAL, default 9: upper count bound, 1 <= MAX_VAL <= 2^WIDTH-1.
REQ-003 Parameter STEP, default 1: increment/decrement per press, 1 <= STEP <= MAX_VAL.
REQ-004 Parameter WRAP, default 0: 0 = saturate at bounds, 1 = wrap around bounds.
REQ-005 Parameter DB_CYCLES, default 4: debounce stability window in clocks (used only with debounce compiled in).
REQ-006 Clk  input  1  single system clock; all logic on rising edge.
REQ-007 Rst  input  1  reset, synchronous and active-high.
REQ-008 Push  input  2  active-low buttons, asynchronous to Clk; Push[1] = up, Push[0] = down; 2'b11 = idle.
REQ-009 Load_en  input  1  active-high synchronous load strobe.
REQ-010 Load_val  input  WIDTH  value loaded when Load_en = 1.
REQ-011 Cnt_o_LED  output  WIDTH  current count, registered.
REQ-012 Max_o  output  1  high while Cnt_o_LED == MAX_VAL, registered.
REQ-013 Min_o  output  1  high while Cnt_o_LED == 0, registered.
REQ-014 Evt_o  output  1  one-cycle pulse on the cycle Cnt_o_LED changes value.

Function
REQ-015 Each Push bit shall pass through a two-flop synchronizer before any use.
REQ-016 A press shall be the 1->0 transition of a synchronized (or debounced) button level; one press = exactly one count action regardless of hold time.
REQ-017 Without debounce, Cnt_o_LED shall show the new value after the 3rd rising Clk edge following the Push transition.
REQ-018 Up press: Cnt_o_LED += STEP; down press: Cnt_o_LED -= STEP.
REQ-019 WRAP=0: result > MAX_VAL shall saturate to MAX_VAL; result < 0 shall saturate to 0.
REQ-020 WRAP=1: up beyond MAX_VAL shall yield (cnt+STEP)-(MAX_VAL+1); down below 0 shall yield cnt-STEP+(MAX_VAL+1); intermediate math WIDTH+1 bits.
REQ-021 Up and down presses detected in the same cycle shall produce no change and no Evt_o.
REQ-022 Load_en = 1 shall override any press in that cycle; Load_val > MAX_VAL shall load MAX_VAL.
REQ-023 Evt_o shall not pulse when the action leaves the count unchanged (saturated press, load of equal value).
REQ-024 Max_o and Min_o shall update in the same cycle as Cnt_o_LED.

Reset
REQ-025 Rst = 1 at a rising edge shall set Cnt_o_LED = 0, Min_o = 1, Max_o = 0, Evt_o = 0, and all synchronizer/edge/debounce state to idle (released).
REQ-026 Rst shall override Load_en and presses in the same cycle.
REQ-027 A button held through reset deassertion shall not count; it must be released and pressed again.

Configuration
REQ-028 Macro BTN_UPDOWN_DEBOUNCE_EN defined: synchronized level shall update only after DB_CYCLES consecutive identical samples, adding exactly DB_CYCLES clocks of latency; pulses shorter than DB_CYCLES clocks shall be ignored.
REQ-029 Macro BTN_UPDOWN_DEBOUNCE_EN undefined: no debounce logic; press detection directly on the synchronized level per REQ-017.

Verification
REQ-030 Defaults, reset, then 9 up presses of 200 ns each -> Cnt_o_LED 0..9, Max_o = 1 at 9, nine Evt_o pulses.
REQ-031 At 9, one more up press (WRAP=0) -> stays 9, no Evt_o; with WRAP=1 -> 0, Min_o = 1.
REQ-032 From 9, 8 down presses -> 1; 2 more -> 0 then stays 0 (WRAP=0), Min_o = 1.
REQ-033 Push = 2'b00 pressed simultaneously at count 5 -> remains 5, no Evt_o; Load_en with Load_val = 12 in same cycle as up press -> 9.
REQ-034 Rst asserted while up held at count 4 -> 0; release Rst with button still held -> stays 0 until release and re-press -> 1.
REQ-035 With BTN_UPDOWN_DEBOUNCE_EN, DB_CYCLES = 4: 3-clock low glitch on Push[1] -> no change; 6-clock press -> +1 exactly DB_CYCLES clocks later than non-debounced build.
